// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared types and helpers for the UART sample link.
// UART_LINK_HEADER_EN adds a header state and a third byte per frame.
package uart_link_pkg;

`ifdef UART_LINK_HEADER_EN
  localparam int BYTES_PER_SAMPLE = 3;
  typedef enum logic [1:0] {RX_HDR, RX_HI, RX_LO} rx_state_t;
`else
  localparam int BYTES_PER_SAMPLE = 2;
  typedef enum logic [1:0] {RX_HI, RX_LO} rx_state_t;
`endif

  localparam int BYTE_IDX_W = $clog2(BYTES_PER_SAMPLE);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_BUSY} tx_state_t;

  // Inter-byte gap in clock cycles; 64-bit math keeps large clocks from overflowing.
  function automatic int unsigned timeout_cycles(longint unsigned clk_hz,
                                                 longint unsigned baud,
                                                 longint unsigned chars);
    longint unsigned c;
    c = chars * 64'd10 * clk_hz / baud;
    return (c == 64'd0) ? 1 : 32'(c);
  endfunction

  function automatic int timeout_width(int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/uart_byte_tx_seq.sv
// rtl/uart_byte_tx_seq.sv - load/busy handshake with the UART transmitter for one byte.
// A start during the completing cycle chains straight into the next load.
module uart_byte_tx_seq
  import uart_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_data,
  output logic       done,
  input  logic       uartTxReadyIn,
  output logic [7:0] uartTxDataOut,
  output logic       uartTxLoadOut
);

  tx_state_t  state, state_nxt;
  logic [7:0] data_q;
  logic       take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= TX_IDLE;
      data_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (take) data_q <= byte_data;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    take      = 1'b0;
    case (state)
      TX_IDLE: if (start) begin
        take      = 1'b1;
        state_nxt = TX_LOAD;
      end
      TX_LOAD: if (!uartTxReadyIn) state_nxt = TX_BUSY;
      TX_BUSY: if (uartTxReadyIn) begin
        done = 1'b1;
        if (start) begin
          take      = 1'b1;
          state_nxt = TX_LOAD;
        end else begin
          state_nxt = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  assign uartTxLoadOut = (state == TX_LOAD);
  assign uartTxDataOut = data_q;

endmodule

// File: rtl/uart_sample_link.sv
// rtl/uart_sample_link.sv - carries 16-bit samples over byte-wide UART RX/TX, MSB first.
// UART_LINK_HEADER_EN prefixes every frame with HEADER_BYTE in both directions.
module uart_sample_link
  import uart_link_pkg::*;
#(
  parameter int          CLOCK_FREQUENCY  = 50_000_000,
  parameter int          BAUD_RATE        = 9600,
  parameter int          RX_TIMEOUT_BYTES = 4,
  parameter logic [7:0]  HEADER_BYTE      = 8'hA5
) (
  input  logic        clkIn,
  input  logic        nResetIn,
  input  logic        uartRxReadyIn,
  input  logic [7:0]  uartRxDataIn,
  input  logic        uartTxReadyIn,
  output logic [7:0]  uartTxDataOut,
  output logic        uartTxLoadOut,
  output logic [15:0] sampleOut,
  output logic        sampleValidOut,
  input  logic        sampleReadyIn,
  input  logic [15:0] resultIn,
  input  logic        resultValidIn,
  output logic        resultReadyOut,
  output logic [7:0]  overrunCountOut,
  output logic [7:0]  timeoutCountOut
);

  localparam int unsigned TIMEOUT = timeout_cycles(64'(CLOCK_FREQUENCY), 64'(BAUD_RATE),
                                                   64'(RX_TIMEOUT_BYTES));
  localparam int TW = timeout_width(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_SAMPLE - 1);
`ifdef UART_LINK_HEADER_EN
  localparam rx_state_t RX_START = RX_HDR;
`else
  localparam rx_state_t RX_START = RX_HI;
`endif

  rx_state_t     rx_state, rx_next;
  logic          rx_ready_q, byte_event, sample_done, timed_out, transfer;
  logic [7:0]    hi_q;
  logic [TW-1:0] timer_q;

  assign byte_event = uartRxReadyIn & ~rx_ready_q;
  assign transfer   = sampleValidOut & sampleReadyIn;

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) rx_state <= RX_START;
    else           rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    sample_done = 1'b0;
    timed_out   = 1'b0;
    if (rx_state != RX_START && !byte_event && timer_q == TMAX) begin
      timed_out = 1'b1;
      rx_next   = RX_START;
    end else if (byte_event) begin
      case (rx_state)
`ifdef UART_LINK_HEADER_EN
        RX_HDR: if (uartRxDataIn == HEADER_BYTE) rx_next = RX_HI;
`endif
        RX_HI: rx_next = RX_LO;
        RX_LO: begin
          rx_next     = RX_START;
          sample_done = 1'b1;
        end
        default: rx_next = RX_START;
      endcase
    end
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      rx_ready_q      <= 1'b0;
      hi_q            <= 8'h00;
      timer_q         <= '0;
      sampleOut       <= 16'h0000;
      sampleValidOut  <= 1'b0;
      overrunCountOut <= 8'h00;
      timeoutCountOut <= 8'h00;
    end else begin
      rx_ready_q <= uartRxReadyIn;
      if (byte_event && rx_state == RX_HI) hi_q <= uartRxDataIn;
      if (byte_event)                 timer_q <= '0;
      else if (rx_state != RX_START)  timer_q <= timer_q + 1'b1;
      if (timed_out && timeoutCountOut != 8'hFF) timeoutCountOut <= timeoutCountOut + 8'd1;
      // A completing sample only displaces the held one if that one leaves this cycle.
      if (sample_done) begin
        if (!sampleValidOut || sampleReadyIn) begin
          sampleOut      <= {hi_q, uartRxDataIn};
          sampleValidOut <= 1'b1;
        end else if (overrunCountOut != 8'hFF) begin
          overrunCountOut <= overrunCountOut + 8'd1;
        end
      end else if (transfer) begin
        sampleValidOut <= 1'b0;
      end
    end
  end

  function automatic logic [7:0] frame_byte(input logic [15:0] word,
                                            input logic [BYTE_IDX_W-1:0] idx);
    logic [23:0] f;
    logic [1:0]  pos;
    f   = {HEADER_BYTE, word};
    pos = 2'(BYTES_PER_SAMPLE - 1) - 2'(idx);
    return f[{pos, 3'b000} +: 8];
  endfunction

  logic                  run_q, tx_active_q, capture, byte_done, more, start;
  logic [BYTE_IDX_W-1:0] idx_q;
  logic [15:0]           hold_q;
  logic [7:0]            start_byte;

  // run_q keeps resultReadyOut low while reset is asserted.
  assign resultReadyOut = run_q & ~tx_active_q;
  assign capture        = resultValidIn & resultReadyOut;
  assign more           = byte_done & (idx_q != LAST_IDX);
  assign start          = capture | more;
  assign start_byte     = capture ? frame_byte(resultIn, '0) : frame_byte(hold_q, idx_q + 1'b1);

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      run_q       <= 1'b0;
      tx_active_q <= 1'b0;
      idx_q       <= '0;
      hold_q      <= 16'h0000;
    end else begin
      run_q <= 1'b1;
      if (capture) begin
        hold_q      <= resultIn;
        idx_q       <= '0;
        tx_active_q <= 1'b1;
      end else if (byte_done) begin
        if (more) idx_q <= idx_q + 1'b1;
        else      tx_active_q <= 1'b0;
      end
    end
  end

  uart_byte_tx_seq u_tx (
    .clk           (clkIn),
    .rst_n         (nResetIn),
    .start         (start),
    .byte_data     (start_byte),
    .done          (byte_done),
    .uartTxReadyIn (uartTxReadyIn),
    .uartTxDataOut (uartTxDataOut),
    .uartTxLoadOut (uartTxLoadOut)
  );

endmodule

// File: tb/tb_uart_sample_link.sv
// tb/tb_uart_sample_link.sv - directed and randomized checks of uart_sample_link.
// Build with UART_LINK_HEADER_EN defined to exercise the header frames.
module tb_uart_sample_link;

  localparam int TO = 400;  // 4 chars * 10 bits * 96000 / 9600
`ifdef UART_LINK_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic        clk, rst_n, rx_rdy, tx_rdy, tx_load, s_valid, s_ready, r_valid, r_ready;
  logic [7:0]  rx_data, tx_data, ovr, tmo;
  logic [15:0] sample, result;

  uart_sample_link #(.CLOCK_FREQUENCY(96_000), .BAUD_RATE(9600), .RX_TIMEOUT_BYTES(4)) dut (
    .clkIn(clk), .nResetIn(rst_n), .uartRxReadyIn(rx_rdy), .uartRxDataIn(rx_data),
    .uartTxReadyIn(tx_rdy), .uartTxDataOut(tx_data), .uartTxLoadOut(tx_load),
    .sampleOut(sample), .sampleValidOut(s_valid), .sampleReadyIn(s_ready),
    .resultIn(result), .resultValidIn(r_valid), .resultReadyOut(r_ready),
    .overrunCountOut(ovr), .timeoutCountOut(tmo)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  // Sample sink: random ready, never low for more than two cycles in a row.
  bit sink_rand = 1'b0;
  int zrun = 0;
  always @(posedge clk) begin
    #1;
    if (sink_rand) begin
      if (zrun >= 2 || $urandom_range(0, 1) == 1) begin
        s_ready = 1'b1;
        zrun = 0;
      end else begin
        s_ready = 1'b0;
        zrun++;
      end
    end
  end

  logic [15:0] got_q[$], exp_q[$];
  always @(negedge clk) if (rst_n && s_valid && s_ready) got_q.push_back(sample);

  // UART transmitter model: accepts a load, drops ready after um_delay, busy um_busy cycles.
  logic [7:0] tx_got[$], tx_exp[$];
  int um_phase = 0, um_cnt = 0, um_delay = 3, um_busy = 100;
  always @(negedge clk) begin
    if (!rst_n) begin
      um_phase = 0;
      tx_rdy = 1'b1;
    end else begin
      case (um_phase)
        0: if (tx_load) begin
          tx_got.push_back(tx_data);
          um_cnt = um_delay;
          um_phase = 1;
        end
        1: begin
          um_cnt--;
          if (um_cnt <= 0) begin
            tx_rdy = 1'b0;
            um_cnt = um_busy;
            um_phase = 2;
          end
        end
        default: begin
          um_cnt--;
          if (um_cnt <= 0) begin
            check("tx_hold", 32'(tx_data), 32'(tx_got[$]));
            check("tx_result_ready_low", 32'(r_ready), 0);
            tx_rdy = 1'b1;
            um_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy = 1'b1;
    tick;
    tick;
    rx_rdy = 1'b0;
    tick;
  endtask

  task automatic rx_hdr;
    if (HDR) begin
      rx_byte(8'hA5);
      idle(20);
    end
  endtask

  task automatic rx_frame(input logic [7:0] hi, input logic [7:0] lo, input int gap);
    rx_hdr;
    rx_byte(hi);
    idle(gap);
    rx_byte(lo);
  endtask

  task automatic send_result(input logic [15:0] w);
    int i;
    for (i = 0; i < 2000 && !r_ready; i++) tick;
    check("result_ready_wait", 32'(r_ready), 1);
    result = w;
    r_valid = 1'b1;
    tick;
    r_valid = 1'b0;
    if (HDR) tx_exp.push_back(8'hA5);
    tx_exp.push_back(w[15:8]);
    tx_exp.push_back(w[7:0]);
  endtask

  task automatic wait_tx_idle(input int budget);
    int i;
    for (i = 0; i < budget && !(r_ready && tx_got.size() == tx_exp.size()); i++) tick;
    check("tx_finish_wait", 32'(r_ready && tx_got.size() == tx_exp.size()), 1);
  endtask

  task automatic cmp_tx(input string tag);
    check({tag, "_count"}, 32'(tx_got.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size(); i++)
      check(tag, (i < tx_got.size()) ? 32'(tx_got[i]) : 32'hDEAD0000, 32'(tx_exp[i]));
    tx_got.delete();
    tx_exp.delete();
  endtask

  task automatic cmp_rx(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD0000, 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  int exp_tmo = 0;

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; tx_rdy = 1'b1;
    s_ready = 1'b0; result = 16'h0000; r_valid = 1'b0;
    idle(3);
    check("reset_outputs", {5'b0, tx_data, sample, tx_load, s_valid, r_ready}, 0);
    check("reset_counts", {16'b0, ovr, tmo}, 0);
    rst_n = 1'b1;
    idle(2);
    check("ready_after_reset", 32'(r_ready), 1);

    // Two bytes two character times apart, valid one cycle after the second edge.
    rx_hdr;
    rx_byte(8'h12);
    idle(197);
    rx_data = 8'h34;
    rx_rdy = 1'b1;
    @(negedge clk);
    check("latency_pre", 32'(s_valid), 0);
    @(negedge clk);
    check("latency_valid", 32'(s_valid), 1);
    check("latency_sample", 32'(sample), 32'h1234);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    tick;
    check("t1_counts", {16'b0, ovr, tmo}, 0);
    s_ready = 1'b1;
    tick;
    exp_q.push_back(16'h1234);
    cmp_rx("t1_sample");
    check("t1_valid_drop", 32'(s_valid), 0);

    // Partial sample abandoned by a long silence.
    rx_hdr;
    rx_byte(8'h12);
    idle(TO + 200);
    rx_frame(8'hAB, 8'hCD, 50);
    idle(5);
    check("t2_timeouts", 32'(tmo), 1);
    exp_q.push_back(16'hABCD);
    cmp_rx("t2_sample");

    // Overrun: second sample dropped while the first is held.
    s_ready = 1'b0;
    rx_frame(8'h00, 8'h01, 10);
    idle(10);
    rx_frame(8'h00, 8'h02, 10);
    idle(5);
    check("t3_held", 32'(sample), 32'h0001);
    check("t3_valid", 32'(s_valid), 1);
    check("t3_overrun", 32'(ovr), 1);
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    idle(3);
    exp_q.push_back(16'h0001);
    cmp_rx("t3_sample");
    check("t3_valid_drop", 32'(s_valid), 0);

    // New sample completes in the cycle the held one transfers.
    rx_frame(8'h11, 8'h11, 10);
    idle(5);
    rx_hdr;
    rx_byte(8'h22);
    idle(10);
    rx_data = 8'h33;
    rx_rdy = 1'b1;
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    tick;
    rx_rdy = 1'b0;
    check("t4_valid_kept", 32'(s_valid), 1);
    check("t4_sample", 32'(sample), 32'h2233);
    check("t4_no_overrun", 32'(ovr), 1);
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2233);
    cmp_rx("t4_order");

    // TX of one result through a slow UART.
    um_delay = 3;
    um_busy = 100;
    send_result(16'hBEEF);
    check("t5_ready_low", 32'(r_ready), 0);
    wait_tx_idle(1000);
    cmp_tx("t5_bytes");

    // Reset in the busy phase of the first byte, then a clean transfer.
    send_result(16'hC3C3);
    for (int i = 0; i < 100 && um_phase != 2; i++) tick;
    check("t6_reach_busy", 32'(um_phase), 2);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {5'b0, tx_data, sample, tx_load, s_valid, r_ready}, 0);
    check("t6_reset_counts", {16'b0, ovr, tmo}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    tx_got.delete();
    tx_exp.delete();
    send_result(16'h5A5A);
    wait_tx_idle(1000);
    cmp_tx("t6_bytes");

`ifdef UART_LINK_HEADER_EN
    s_ready = 1'b1;
    rx_byte(8'h00); idle(10);
    rx_byte(8'hA5); idle(10);
    rx_byte(8'h12); idle(10);
    rx_byte(8'h34); idle(5);
    exp_q.push_back(16'h1234);
    cmp_rx("hdr_rx");
    send_result(16'h0102);
    wait_tx_idle(1000);
    cmp_tx("hdr_tx");
    s_ready = 1'b0;
`endif

    // Randomized RX and TX traffic running concurrently.
    fork
      begin
        sink_rand = 1'b1;
        for (int f = 0; f < 16; f++) begin
          if ($urandom_range(0, 3) == 0) begin
            rx_hdr;
            rx_byte(8'($urandom));
            idle(TO + 50 + $urandom_range(0, 50));
            exp_tmo++;
          end else begin
            logic [15:0] w;
            w = 16'($urandom);
            rx_frame(w[15:8], w[7:0], $urandom_range(5, 150));
            exp_q.push_back(w);
          end
          idle($urandom_range(5, 60));
        end
        idle(10);
        sink_rand = 1'b0;
      end
      begin
        for (int r = 0; r < 8; r++) begin
          um_delay = $urandom_range(1, 4);
          um_busy = $urandom_range(1, 20);
          send_result(16'($urandom));
          idle($urandom_range(0, 5));
        end
        wait_tx_idle(2000);
      end
    join
    cmp_rx("rand_rx");
    check("rand_timeouts", 32'(tmo), 32'(exp_tmo));
    check("rand_overrun", 32'(ovr), 0);
    cmp_tx("rand_tx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_sample_link.md
Name: uart_sample_link

Overview:
- Sequences the UART byte transmitter/receiver pair to carry 16-bit filter samples between a host and the FIR datapath.
- RX side: assembles two received bytes, MSB first, into one sample and presents it on a valid/ready port to the filter input.
- TX side: accepts one 16-bit filter result on a valid/ready port and serialises it into two UART TX loads, MSB first.
- Adds inter-byte timeout resynchronisation and overrun counting.

Parameters:
- CLOCK_FREQUENCY, 50_000_000, system clock in Hz.
- BAUD_RATE, 9600, UART bit rate; used only for the timeout.
- RX_TIMEOUT_BYTES, 4, inter-byte gap, in 10-bit character times, after which a partial sample is discarded.
- HEADER_BYTE, 8'hA5, frame header value; used only with UART_LINK_HEADER_EN.

Ports:
- clkIn  in  1  system clock.
- nResetIn  in  1  asynchronous active-low reset.
- uartRxReadyIn  in  1  UART RX byte-available level.
- uartRxDataIn  in  8  UART RX byte.
- uartTxReadyIn  in  1  UART TX can accept a byte.
- uartTxDataOut  out  8  byte to UART TX.
- uartTxLoadOut  out  1  UART TX load strobe/hold.
- sampleOut  out  16  assembled input sample to FIR.
- sampleValidOut  out  1  sampleOut valid.
- sampleReadyIn  in  1  FIR accepts sample.
- resultIn  in  16  FIR output sample.
- resultValidIn  in  1  resultIn valid.
- resultReadyOut  out  1  link accepts result.
- overrunCountOut  out  8  saturating count of dropped RX samples.
- timeoutCountOut  out  8  saturating count of discarded partial samples.

Behaviour:
- Reset (async assert, sync release) clears every register.
  - All outputs 0.
  - RX FSM = RX_HI; TX FSM = TX_IDLE.
- RX byte event = rising edge of uartRxReadyIn, registered edge detect. Data is captured from uartRxDataIn on that cycle.
- RX FSM, RX_HI -> RX_LO:
  - On a byte event, store the high byte and start the timeout counter.
  - Timeout = RX_TIMEOUT_BYTES*10*CLOCK_FREQUENCY/BAUD_RATE cycles, integer, computed at elaboration.
- RX_LO -> RX_HI on a byte event:
  - sampleOut <= {hi, byte}; sampleValidOut <= 1 on the next cycle. Latency from the second byte event to valid is 1 cycle.
- RX_LO timeout expiry: discard the high byte, timeoutCountOut++ (saturates at 255), return to RX_HI.
- Sample handshake: transfer when sampleValidOut & sampleReadyIn. sampleValidOut then drops next cycle unless a new sample completes in that same cycle.
- New sample completes while sampleValidOut=1 & !sampleReadyIn:
  - The new sample is dropped and the held sample is kept.
  - overrunCountOut++ (saturates at 255).
- New sample completes in the same cycle the old one transfers: the new sample loads, valid stays 1, no overrun.
- resultReadyOut = 1 only in TX_IDLE. A result is captured into a 16-bit holding register on resultValidIn & resultReadyOut.
- TX FSM:
  - TX_IDLE -> TX_LOAD (byte index 0) on result capture.
  - TX_LOAD: uartTxDataOut = selected byte, uartTxLoadOut = 1. Hold until uartTxReadyIn = 0 (UART acknowledged), then -> TX_BUSY.
  - TX_BUSY: uartTxLoadOut = 0. Wait for uartTxReadyIn = 1. Then if index = 0, go to index 1 and TX_LOAD; else -> TX_IDLE.
- uartTxDataOut holds its value from TX_LOAD entry through TX_BUSY.
- RX and TX paths are fully independent; simultaneous activity is allowed.
- Reset mid-transfer abandons any partial byte pair with no completion; uartTxLoadOut drops asynchronously.

Optional Feature:
- Macro UART_LINK_HEADER_EN.
- Defined:
  - RX adds state RX_HDR before RX_HI. Bytes not equal to HEADER_BYTE are ignored in RX_HDR.
  - A timeout returns to RX_HDR.
  - TX sends HEADER_BYTE as byte index 0 before the high and low bytes, giving a 2-bit byte index.
- Undefined: no header; two-byte frames exactly as above.

Decomposition:
- Package uart_link_pkg:
  - RX and TX state enums.
  - BYTES_PER_SAMPLE localparam (2, or 3 with the header).
  - Function computing the timeout cycle count and its counter width via $clog2.
- One sub-module uart_byte_tx_seq: the TX_LOAD/TX_BUSY handshake for a single byte, with ports start, byte, done, uartTx*. The top-level TX FSM iterates it over the byte index.

Test Plan:
- RX 8'h12 then 8'h34, 2 char-times apart -> one sampleValidOut with sampleOut=16'h1234, 1 cycle after the 2nd edge; counters 0.
- RX 8'h12, then silence longer than 4 char-times, then 8'hAB, 8'hCD -> timeoutCountOut=1, single sample 16'hABCD.
- sampleReadyIn held 0; two full samples 16'h0001 and 16'h0002 -> sampleOut stays 16'h0001, overrunCountOut=1. Release ready -> one transfer.
- resultIn=16'hBEEF with valid; UART model drops ready 3 cycles after load and is busy 100 cycles -> loads 8'hBE then 8'hEF. resultReadyOut=0 until the 2nd byte completes.
- Assert nResetIn=0 while in TX_BUSY of the 1st byte -> all outputs 0 immediately. After release, a new result 16'h5A5A sends both bytes cleanly.
- UART_LINK_HEADER_EN: RX 8'h00, 8'hA5, 8'h12, 8'h34 -> sample 16'h1234. TX of 16'h0102 emits A5, 01, 02.
